// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Hardwired Moore control unit for a small bus-based CPU. Walks every
//   instruction through a three-step fetch (T0-T2) and up to four execute
//   steps (T3-T6). Every output is a combinational function of the current
//   state and ir. In T6 the branch write-back also depends on con_ff.
//
// Ports
//   clock       in   1   rising-edge system clock
//   clear       in   1   asynchronous reset, active low
//   ir          in  32   instruction register: op=ir[31:27], Ra=ir[26:23],
//                        Rb=ir[22:19], Rc=ir[18:15]
//   con_ff      in   1   branch condition (Ra == 0), valid the cycle after CONin
//   Rin         out 32   bus-load enables: 0-15 R0-R15, 19 Zlow, 20 PC, 21 MDR
//   Rout        out 32   bus-drive selects: 0-15 R0-R15, 19 Zlow, 20 PC,
//                        21 MDR, 23 C (sign-extended ir[18:0])
//   ALUControl  out 16   ALU operation code
//   IRin, MARin, RYin, MDRread, CONin   out 1 each   single-register enables
//   run         out  1   high while instructions are being executed
// ----------------------------------------------------------------------------
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        con_ff,
   output logic [31:0] Rin,
   output logic [31:0] Rout,
   output logic [15:0] ALUControl,
   output logic        IRin,
   output logic        MARin,
   output logic        RYin,
   output logic        MDRread,
   output logic        CONin,
   output logic        run
);

   // Special-register bit positions on the Rin / Rout vectors
   localparam int ZLOW_BIT = 19;
   localparam int PC_BIT   = 20;
   localparam int MDR_BIT  = 21;
   localparam int C_BIT    = 23;

   localparam logic [15:0] ALU_ADD   = 16'd1;
   localparam logic [15:0] ALU_INCPC = 16'd9;

   localparam logic [4:0] OP_BRZR = 5'd11;
   localparam logic [4:0] OP_HALT = 5'd13;

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Instruction fields; only consulted from T3 onward, when ir is valid
   logic [4:0] op;
   logic [4:0] ra_idx;
   logic [4:0] rb_idx;
   logic [4:0] rc_idx;
   logic       is_rform;
   logic       is_iform;
   logic       is_brzr;
   logic [15:0] alu_code;

   // The immediate itself goes straight to the datapath via the C register
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[14:0];

   assign op       = ir[31:27];
   assign ra_idx   = {1'b0, ir[26:23]};
   assign rb_idx   = {1'b0, ir[22:19]};
   assign rc_idx   = {1'b0, ir[18:15]};
   assign is_rform = (op <= 5'd7);
   assign is_iform = (op >= 5'd8) && (op <= 5'd10);
   assign is_brzr  = (op == OP_BRZR);

   always_comb begin
      alu_code = 16'd0;
      case (op)
         5'd0:    alu_code = 16'd1;   // add
         5'd1:    alu_code = 16'd2;   // sub
         5'd2:    alu_code = 16'd3;   // and
         5'd3:    alu_code = 16'd4;   // or
         5'd4:    alu_code = 16'd5;   // shr
         5'd5:    alu_code = 16'd6;   // shl
         5'd6:    alu_code = 16'd7;   // rol
         5'd7:    alu_code = 16'd8;   // ror
         5'd8:    alu_code = 16'd1;   // addi
         5'd9:    alu_code = 16'd3;   // andi
         5'd10:   alu_code = 16'd4;   // ori
         default: alu_code = 16'd0;
      endcase
   end

   // State register: clear drops the sequencer into RST at once
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_reg <= ST_RST;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RST:  state_next = ST_T0;
         ST_T0:   state_next = ST_T1;
         ST_T1:   state_next = ST_T2;
         ST_T2:   state_next = ST_T3;
         ST_T3:   state_next = (op == OP_HALT) ? ST_HALT : ST_T4;
         ST_T4:   state_next = ST_T5;
         ST_T5:   state_next = is_brzr ? ST_T6 : ST_T0;
         ST_T6:   state_next = ST_T0;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_RST;
      endcase
   end

   // Output logic
   always_comb begin
      Rin        = 32'd0;
      Rout       = 32'd0;
      ALUControl = 16'd0;
      IRin       = 1'b0;
      MARin      = 1'b0;
      RYin       = 1'b0;
      MDRread    = 1'b0;
      CONin      = 1'b0;
      run        = (state_reg != ST_RST) && (state_reg != ST_HALT);

      case (state_reg)
         ST_T0: begin
            // PC -> MAR and start PC+1 into Z in the same step
            Rout[PC_BIT]  = 1'b1;
            MARin         = 1'b1;
            Rin[ZLOW_BIT] = 1'b1;
            ALUControl    = ALU_INCPC;
         end
         ST_T1: begin
            Rout[ZLOW_BIT] = 1'b1;
            Rin[PC_BIT]    = 1'b1;
            MDRread        = 1'b1;
            Rin[MDR_BIT]   = 1'b1;
         end
         ST_T2: begin
            Rout[MDR_BIT] = 1'b1;
            IRin          = 1'b1;
         end
         ST_T3: begin
            if (is_rform || is_iform) begin
               Rout[rb_idx] = 1'b1;
               RYin         = 1'b1;
            end else if (is_brzr) begin
               Rout[ra_idx] = 1'b1;
               CONin        = 1'b1;
            end
         end
         ST_T4: begin
            if (is_rform || is_iform) begin
               // Second operand is Rc for R-format, the constant for I-format
               if (is_rform) begin
                  Rout[rc_idx] = 1'b1;
               end else begin
                  Rout[C_BIT] = 1'b1;
               end
               ALUControl    = alu_code;
               Rin[ZLOW_BIT] = 1'b1;
            end else if (is_brzr) begin
               Rout[PC_BIT] = 1'b1;
               RYin         = 1'b1;
            end
         end
         ST_T5: begin
            if (is_rform || is_iform) begin
               Rout[ZLOW_BIT] = 1'b1;
               Rin[ra_idx]    = 1'b1;
            end else if (is_brzr) begin
               // Branch target PC + C is computed unconditionally
               Rout[C_BIT]   = 1'b1;
               ALUControl    = ALU_ADD;
               Rin[ZLOW_BIT] = 1'b1;
            end
         end
         ST_T6: begin
            // Commit the branch target only when the condition held
            if (con_ff) begin
               Rout[ZLOW_BIT] = 1'b1;
               Rin[PC_BIT]    = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic        clock;
   logic        clear;
   logic [31:0] ir;
   logic        con_ff;
   logic [31:0] Rin;
   logic [31:0] Rout;
   logic [15:0] ALUControl;
   logic        IRin;
   logic        MARin;
   logic        RYin;
   logic        MDRread;
   logic        CONin;
   logic        run;

   int compared;
   int mismatched;
   logic onehot_check_en;

   // Every output packed together, run in bit 0
   logic [85:0] all_out;
   assign all_out = {Rin, Rout, ALUControl, IRin, MARin, RYin, MDRread, CONin, run};

   control_sequencer dut (
      .clock      (clock),
      .clear      (clear),
      .ir         (ir),
      .con_ff     (con_ff),
      .Rin        (Rin),
      .Rout       (Rout),
      .ALUControl (ALUControl),
      .IRin       (IRin),
      .MARin      (MARin),
      .RYin       (RYin),
      .MDRread    (MDRread),
      .CONin      (CONin),
      .run        (run)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [85:0] obs, input logic [85:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one state and sample at the falling edge
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Entered in T0; checks the three fetch steps and leaves the FSM in T3
   task automatic run_fetch(input string name);
      chk({name, " T0 Rout"}, 86'(Rout), 86'h100000);
      chk({name, " T0 ALU"}, 86'(ALUControl), 86'd9);
      chk({name, " T0 MARin"}, 86'(MARin), 86'd1);
      chk({name, " T0 Rin"}, 86'(Rin), 86'h80000);
      chk({name, " T0 run"}, 86'(run), 86'd1);
      step();
      chk({name, " T1 Rout"}, 86'(Rout), 86'h80000);
      chk({name, " T1 Rin"}, 86'(Rin), 86'h300000);
      chk({name, " T1 MDRread"}, 86'(MDRread), 86'd1);
      step();
      chk({name, " T2 Rout"}, 86'(Rout), 86'h200000);
      chk({name, " T2 IRin"}, 86'(IRin), 86'd1);
      chk({name, " T2 Rin"}, 86'(Rin), 86'd0);
      step();
   endtask

   // Rout must never select more than one bus driver
   always @(negedge clock) begin
      if (onehot_check_en) begin
         compared++;
         assert ($onehot0(Rout)) else begin
            mismatched++;
            $error("FAIL rout_onehot: observed %0h required one-hot or zero", Rout);
         end
      end
   end

   initial begin
      compared        = 0;
      mismatched      = 0;
      onehot_check_en = 1'b0;
      clear           = 1'b0;
      ir              = 32'd0;
      con_ff          = 1'b0;

      @(negedge clock);
      @(negedge clock);
      onehot_check_en = 1'b1;
      chk("reset all outputs", all_out, 86'd0);
      $display("txn reset: outputs idle at %0t", $time);

      // rol R2, R4, R0
      ir    = 32'h31200000;
      clear = 1'b1;
      step();
      run_fetch("rol");
      chk("rol T3 Rout", 86'(Rout), 86'h10);
      chk("rol T3 RYin", 86'(RYin), 86'd1);
      step();
      chk("rol T4 ALU", 86'(ALUControl), 86'd7);
      chk("rol T4 Rout", 86'(Rout), 86'h1);
      chk("rol T4 Rin", 86'(Rin), 86'h80000);
      step();
      chk("rol T5 Rout", 86'(Rout), 86'h80000);
      chk("rol T5 Rin", 86'(Rin), 86'h4);
      step();
      $display("txn rol: completed at %0t", $time);

      // addi R1, R4, -1
      ir = 32'h40A7FFFF;
      run_fetch("addi");
      chk("addi T3 Rout", 86'(Rout), 86'h10);
      step();
      chk("addi T4 Rout", 86'(Rout), 86'h800000);
      chk("addi T4 ALU", 86'(ALUControl), 86'd1);
      chk("addi T4 Rin", 86'(Rin), 86'h80000);
      step();
      chk("addi T5 Rin", 86'(Rin), 86'h2);
      chk("addi T5 Rout", 86'(Rout), 86'h80000);
      step();
      $display("txn addi: completed at %0t", $time);

      // brzr R3, taken
      ir = 32'h59800000;
      run_fetch("brzr1");
      chk("brzr1 T3 Rout", 86'(Rout), 86'h8);
      chk("brzr1 T3 CONin", 86'(CONin), 86'd1);
      con_ff = 1'b1;
      step();
      chk("brzr1 T4 Rout", 86'(Rout), 86'h100000);
      chk("brzr1 T4 RYin", 86'(RYin), 86'd1);
      step();
      chk("brzr1 T5 Rout", 86'(Rout), 86'h800000);
      chk("brzr1 T5 ALU", 86'(ALUControl), 86'd1);
      chk("brzr1 T5 Rin", 86'(Rin), 86'h80000);
      step();
      chk("brzr1 T6 Rout", 86'(Rout), 86'h80000);
      chk("brzr1 T6 Rin", 86'(Rin), 86'h100000);
      step();
      chk("brzr1 back to T0", 86'(Rout), 86'h100000);
      $display("txn brzr taken: completed at %0t", $time);

      // brzr R3, not taken
      con_ff = 1'b0;
      run_fetch("brzr0");
      chk("brzr0 T3 Rout", 86'(Rout), 86'h8);
      step();
      step();
      chk("brzr0 T5 Rin", 86'(Rin), 86'h80000);
      step();
      chk("brzr0 T6 outputs", all_out, 86'd1);
      step();
      chk("brzr0 back to T0", 86'(Rout), 86'h100000);
      $display("txn brzr not taken: completed at %0t", $time);

      // undefined op 20
      ir = 32'hA0000000;
      run_fetch("undef");
      chk("undef T3 outputs", all_out, 86'd1);
      step();
      chk("undef T4 outputs", all_out, 86'd1);
      step();
      chk("undef T5 outputs", all_out, 86'd1);
      step();
      chk("undef refetch T0", 86'(Rout), 86'h100000);
      $display("txn undefined op: completed at %0t", $time);

      // add R5, R6, R7 interrupted by reset in T4
      ir = {5'd0, 4'd5, 4'd6, 4'd7, 15'd0};
      run_fetch("add");
      chk("add T3 Rout", 86'(Rout), 86'h40);
      step();
      chk("add T4 Rout", 86'(Rout), 86'h80);
      chk("add T4 ALU", 86'(ALUControl), 86'd1);
      #2 clear = 1'b0;
      #1;
      chk("add reset immediate", all_out, 86'd0);
      step();
      chk("add reset held", all_out, 86'd0);
      clear = 1'b1;
      step();
      chk("post-reset T0 Rout", 86'(Rout), 86'h100000);
      chk("post-reset T0 run", 86'(run), 86'd1);
      $display("txn add with mid-T4 reset: completed at %0t", $time);

      // halt
      ir = 32'h68000000;
      run_fetch("halt");
      chk("halt T3 outputs", all_out, 86'd1);
      for (int i = 0; i < 11; i++) begin
         step();
         chk($sformatf("halt cycle %0d", i), all_out, 86'd0);
      end
      $display("txn halt: completed at %0t", $time);

      onehot_check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net against a stuck simulation
   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  rising-edge system clock.
REQ-002 SHALL have port: clear  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: ir  in  32  instruction register contents from datapath; fields op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-004 SHALL have port: con_ff  in  1  branch-condition flag from datapath (1 = Ra equals zero), valid in the cycle after CONin.
REQ-005 SHALL have port: Rin  out  32  bus-load enables; bits 0-15 = R0-R15 in, 19 = Zlowin, 20 = PCin, 21 = MDRin.
REQ-006 SHALL have port: Rout  out  32  bus-drive selects; bits 0-15 = R0-R15 out, 19 = Zlowout, 20 = PCout, 21 = MDRout, 23 = Cout (sign-extended ir[18:0]).
REQ-007 SHALL have port: ALUControl  out  16  ALU operation code.
REQ-008 SHALL have ports: IRin, MARin, RYin, MDRread, CONin  out  1 each  single-register enables.
REQ-009 SHALL have port: run  out  1  high while the sequencer is executing instructions.

Function
REQ-010 SHALL be a Moore FSM with states RST, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs are combinational in state and ir; every output not listed for a state is 0.
REQ-011 Rout SHALL be one-hot or zero in every state.
REQ-012 Fetch: T0 = Rout[20], MARin, Rin[19], ALUControl=9 (IncPC); T1 = Rout[19], Rin[20], MDRread, Rin[21]; T2 = Rout[21], IRin.
REQ-013 Transitions: RST->T0 on the first rising edge after clear is released; T0->T1->T2->T3->T4->T5 unconditionally; decode SHALL use ir in T3 and later only.
REQ-014 ALU code table SHALL be: op 0 add=1, 1 sub=2, 2 and=3, 3 or=4, 4 shr=5, 5 shl=6, 6 rol=7, 7 ror=8, 8 addi=1, 9 andi=3, 10 ori=4.
REQ-015 R-format (op 0-7): T3 = Rout[Rb], RYin; T4 = Rout[Rc], ALUControl=code, Rin[19]; T5 = Rout[19], Rin[Ra]; T5->T0.
REQ-016 I-format (op 8-10): T3 = Rout[Rb], RYin; T4 = Rout[23], ALUControl=code, Rin[19]; T5 = Rout[19], Rin[Ra]; T5->T0.
REQ-017 brzr (op 11): T3 = Rout[Ra], CONin; T4 = Rout[20], RYin; T5 = Rout[23], ALUControl=1, Rin[19]; T5->T6; T6 = Rout[19] and Rin[20] only if con_ff=1, otherwise no outputs; T6->T0.
REQ-018 nop (op 12) and all undefined ops (14-31): T3, T4, T5 drive no outputs; T5->T0.
REQ-019 halt (op 13): T3->HALT, with no outputs driven in T3; HALT SHALL be absorbing, drive all outputs 0 and drive run=0.
REQ-020 run SHALL be 1 in T0-T6 and 0 in RST and HALT.
REQ-021 Ra, Rb, Rc SHALL index Rin/Rout bits 0-15 directly; no register other than the indexed one is enabled.

Reset
REQ-022 clear=0 SHALL force state RST immediately, regardless of the clock and of any instruction in progress.
REQ-023 In RST, all outputs SHALL be 0: Rin=0, Rout=0, ALUControl=0, IRin, MARin, RYin, MDRread, CONin and run all 0.
REQ-024 Reset asserted mid-instruction SHALL abandon that instruction; no partial write-back enable appears after clear falls.

Verification
REQ-025 Fetch + rol: release clear, ir=0x31200000 (op 6, Ra=2, Rb=4, Rc=0) -> T0 Rout=0x100000 and ALUControl=9; T4 ALUControl=7 and Rout=0x1; T5 Rout=0x80000 and Rin=0x4.
REQ-026 addi: ir=0x40A7FFFF (op 8, Ra=1, Rb=4, C=-1) -> T3 Rout=0x10; T4 Rout=0x800000, ALUControl=1, Rin=0x80000; T5 Rin=0x2.
REQ-027 brzr taken/not-taken: op 11, con_ff=1 -> T6 Rout=0x80000 and Rin=0x100000; repeat with con_ff=0 -> T6 Rin=0 and Rout=0; T6->T0 in both cases.
REQ-028 halt: ir=0x68000000 -> HALT after T3, run=0, all outputs 0 for 10 further cycles.
REQ-029 Reset mid-T4: drop clear between clock edges during an add -> outputs 0 in the same time step; after release, T0 on the next rising edge.
REQ-030 Undefined op 20: T3-T5 drive no outputs, then refetch in T0; checker asserts Rout one-hot or zero every cycle.
